cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (result broadcast path) between the functional units (Add slots 1-4, Sub slots 5-7, spare slot 8).
- Units present finished results with a level request. The arbiter grants one per cycle, round-robin, and drives a registered broadcast (tag, value, branch-fail) that the reorder buffer and reservation stations snoop.
- A flush input squashes in-flight broadcasts on branch mispredict.
- Replaces the current free-for-all scan of per-unit result_available.

Parameters:
- NUM_UNITS, 8, number of requesting units; unit i (0-based) owns tag i+1; tag 0 means "no unit".
- DATA_W, 32, result width.
- TAG_W, 8, tag width; matches the reservation station alu field.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- CLOCK_50  in  1  clock, rising edge.
- RSTN_N  in  1  asynchronous active-low reset.
- req  in  NUM_UNITS  bit i: unit i holds a finished result.
- req_value  in  NUM_UNITS*DATA_W  unit i value at bits [i*DATA_W +: DATA_W].
- req_branch_fail  in  NUM_UNITS  unit i branch-mispredict flag, meaningful only for branch ops.
- flush  in  1  mispredict squash from the commit stage.
- grant  out  NUM_UNITS  one-hot or zero; combinational.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  granted unit index+1, registered.
- cdb_value  out  DATA_W  registered.
- cdb_branch_fail  out  1  registered.
- contention_cnt  out  CNT_W  cycles with 2 or more requests; saturating.

Behaviour:
- Reset (async, RSTN_N=0):
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_branch_fail=0, contention_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - grant=0 while RSTN_N=0.
  - Reset deasserting mid-operation discards any pending broadcast; units keep their req high and are re-arbitrated.
- Grant (combinational):
  - Search req starting at index rr_ptr upward, wrapping at NUM_UNITS-1 to 0.
  - First set bit wins; grant is one-hot on it.
  - grant=0 if req=0 or flush=1.
- Handshake:
  - A unit keeps req, req_value and req_branch_fail stable until it samples grant[i]=1 at a rising edge.
  - It drops req (or presents its next result) in the following cycle.
  - The arbiter never grants the same request twice: the winner is consumed at that edge.
- Broadcast latency: exactly 1 cycle. At the edge where grant[i]=1:
  - cdb_valid<=1, cdb_tag<=i+1.
  - cdb_value<=req_value[i], cdb_branch_fail<=req_branch_fail[i].
  - rr_ptr<=(i+1) mod NUM_UNITS; i=NUM_UNITS-1 wraps to 0.
- Idle: at an edge with no grant, cdb_valid<=0 and cdb_tag<=0. cdb_value and cdb_branch_fail hold their last values.
- Flush:
  - At an edge with flush=1: cdb_valid<=0, cdb_tag<=0.
  - No grant that cycle; rr_ptr unchanged.
  - A broadcast already registered in the previous cycle is visible one cycle only; the flush does not retract it.
- Contention: at each edge where popcount(req)>=2 and flush=0, contention_cnt increments. It saturates at 2^CNT_W-1 and does not wrap.
- Fairness: a unit holding req is granted within NUM_UNITS cycles, excluding flush cycles.
- Width rules: tag arithmetic is unsigned TAG_W. NUM_UNITS+1 must be <= 2^TAG_W-1; check this at elaboration.

Test Plan:
- Reset, then a single request: req=8'b0000_0100, req_value[2]=32'd42. Required: grant=8'b0000_0100 the same cycle; next cycle cdb_valid=1, cdb_tag=3, cdb_value=42; rr_ptr=3.
- All units request with req=8'hFF held, rr_ptr=0 after reset. Required: cdb_tag sequence 1,2,3,4,5,6,7,8,1 over nine cycles; contention_cnt=9.
- Wrap-around: rr_ptr=7 after granting unit 6, with req=8'b1000_0001. Required: unit 7 (tag 8) granted first, then unit 0 (tag 1).
- Flush during contention: req=8'b0011_0000 with flush=1 for one cycle. Required: grant=0, cdb_valid=0 next cycle, contention_cnt unchanged, rr_ptr unchanged; the next cycle grants unit 4 (tag 5) when rr_ptr<=4.
- Branch flag passthrough: unit 5 with req_value=0 and req_branch_fail=1. Required: cdb_tag=6, cdb_branch_fail=1.
- Async reset mid-broadcast and counter saturation:
  - RSTN_N low between edges while cdb_valid=1. Required: all outputs zero immediately, with no clock edge needed.
  - Force contention for 65536 cycles. Required: contention_cnt=16'hFFFF and held.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one finished unit per cycle and registers its
// tag/value/branch-fail broadcast one cycle later; losers hold req until granted, flush suppresses grants.
module cdb_arbiter #(
  parameter int NUM_UNITS = 8,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          RSTN_N,
  input  logic [NUM_UNITS-1:0]          req,
  input  logic [NUM_UNITS*DATA_W-1:0]   req_value,
  input  logic [NUM_UNITS-1:0]          req_branch_fail,
  input  logic                          flush,
  output logic [NUM_UNITS-1:0]          grant,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_value,
  output logic                          cdb_branch_fail,
  output logic [CNT_W-1:0]              contention_cnt
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_UNITS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_UNITS - 1);

  // Tag 0 is reserved for "no unit", so the highest tag NUM_UNITS must stay below all-ones.
  if ((longint'(NUM_UNITS) + 1) > ((longint'(1) << TAG_W) - 1)) begin : g_tag_w_check
    $error("cdb_arbiter: TAG_W too narrow to hold NUM_UNITS+1");
  end

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]    cdb_value_q, cdb_value_d;
  logic                 cdb_bf_q, cdb_bf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_UNITS-1:0] req_rot;
  logic [PTR_W-1:0]     win_off;
  logic [PTR_W:0]       idx_sum;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_vld;
  logic                 arb_en;
  logic                 multi_req;
  logic [DATA_W-1:0]    win_value;
  logic                 win_bf;

  // Rotate so bit 0 is the unit at rr_ptr; the lowest set bit is then the round-robin winner.
  assign req_rot = NUM_UNITS'({req, req} >> rr_ptr_q);
  assign win_vld = |req_rot;
  assign arb_en  = RSTN_N && !flush;

  always_comb begin
    win_off = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = PTR_W'(k);
      end
    end
  end

  assign idx_sum = {1'b0, win_off} + {1'b0, rr_ptr_q};
  assign win_idx = (idx_sum >= NUM_EXT) ? PTR_W'(idx_sum - NUM_EXT) : PTR_W'(idx_sum);

  always_comb begin
    grant = '0;
    if (arb_en && win_vld) begin
      grant[win_idx] = 1'b1;
    end
  end

  always_comb begin
    win_value = '0;
    win_bf    = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        win_value = req_value[i*DATA_W +: DATA_W];
        win_bf    = req_branch_fail[i];
      end
    end
  end

  // Two or more bits set exactly when clearing the lowest set bit leaves something behind.
  assign multi_req = |(req & (req - NUM_UNITS'(1)));

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_value_d = cdb_value_q;
    cdb_bf_d    = cdb_bf_q;
    rr_ptr_d    = rr_ptr_q;
    if (|grant) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = TAG_W'(win_idx) + TAG_W'(1);
      cdb_value_d = win_value;
      cdb_bf_d    = win_bf;
      rr_ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (multi_req && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_bf_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_bf_q    <= cdb_bf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cdb_valid       = cdb_valid_q;
  assign cdb_tag         = cdb_tag_q;
  assign cdb_value       = cdb_value_q;
  assign cdb_branch_fail = cdb_bf_q;
  assign contention_cnt  = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_arbiter;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int CW = 16;

  logic              CLOCK_50 = 1'b0;
  logic              RSTN_N;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_value;
  logic [N-1:0]      req_branch_fail;
  logic              flush;
  logic [N-1:0]      grant;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_value;
  logic              cdb_branch_fail;
  logic [CW-1:0]     contention_cnt;

  cdb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N), .req(req), .req_value(req_value),
    .req_branch_fail(req_branch_fail), .flush(flush), .grant(grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_branch_fail(cdb_branch_fail), .contention_cnt(contention_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [DW-1:0] v;
    logic          bf;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [N-1:0]  pend;
  logic [DW-1:0] pval[N];
  logic          pbf[N];
  int            m_rr;
  int            m_cnt;
  bit            mon_en = 1'b0;
  logic [DW-1:0] last_v;
  logic          last_bf;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic post(input int i, input logic [DW-1:0] v, input logic b);
    pend[i] = 1'b1;
    pval[i] = v;
    pbf[i]  = b;
  endtask

  // Spec rule: first requesting unit at or after the pointer, wrapping; nothing while flushing.
  function automatic int model_win(input logic [N-1:0] r, input bit fl);
    if (fl) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input bit fl, output logic [N-1:0] g);
    int w;
    logic [N-1:0] eg;
    exp_t e;
    @(negedge CLOCK_50);
    req = pend;
    for (int i = 0; i < N; i++) begin
      req_value[i*DW +: DW] = pval[i];
      req_branch_fail[i]    = pbf[i];
    end
    flush = fl;
    #1;
    g  = grant;
    w  = model_win(pend, fl);
    eg = (w >= 0) ? (N'(1) << w) : '0;
    chk("grant", 64'(g), 64'(eg));
    chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    if (!fl && $countones(pend) >= 2 && m_cnt < 65535) m_cnt++;
    if (w >= 0) begin
      e.v = pval[w];
      e.bf = pbf[w];
      e.tag = TW'(w + 1);
      exp_q.push_back(e);
      m_rr = (w + 1) % N;
      pend[w] = 1'b0;
    end
  endtask

  task automatic do_reset(input bit expect_valid);
    @(posedge CLOCK_50);
    #3;
    if (expect_valid) chk("pre_reset_valid", 64'(cdb_valid), 64'(1));
    RSTN_N = 1'b0;
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_tag", 64'(cdb_tag), 64'(0));
    chk("rst_value", 64'(cdb_value), 64'(0));
    chk("rst_bf", 64'(cdb_branch_fail), 64'(0));
    chk("rst_cnt", 64'(contention_cnt), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #2;
    RSTN_N = 1'b1;
    m_rr  = 0;
    m_cnt = 0;
  endtask

  // Monitor: pops an expectation for every broadcast; idle cycles must keep tag 0 and hold the data.
  initial begin
    exp_t e;
    last_v  = '0;
    last_bf = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (mon_en) begin
        if (!RSTN_N) begin
          last_v  = '0;
          last_bf = 1'b0;
        end else if (cdb_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_bcast actual tag=%0d required no broadcast at %0t", cdb_tag, $time);
          end else begin
            e = exp_q.pop_front();
            chk("bcast_tag", 64'(cdb_tag), 64'(e.tag));
            chk("bcast_value", 64'(cdb_value), 64'(e.v));
            chk("bcast_bf", 64'(cdb_branch_fail), 64'(e.bf));
            last_v  = e.v;
            last_bf = e.bf;
          end
        end else begin
          chk("idle_tag", 64'(cdb_tag), 64'(0));
          chk("idle_value_hold", 64'(cdb_value), 64'(last_v));
          chk("idle_bf_hold", 64'(cdb_branch_fail), 64'(last_bf));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    RSTN_N = 1'b1;
    flush  = 1'b0;
    req    = 8'hFF;
    req_value = '0;
    req_branch_fail = '0;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      pval[i] = '0;
      pbf[i]  = 1'b0;
    end
    m_rr = 0;
    m_cnt = 0;
    do_reset(1'b0);
    mon_en = 1'b1;

    // Single request from unit 2.
    post(2, 32'd42, 1'b0);
    step(1'b0, g);
    chk("single_grant", 64'(g), 64'(8'h04));
    @(posedge CLOCK_50);
    #1;
    chk("single_valid", 64'(cdb_valid), 64'(1));
    chk("single_tag", 64'(cdb_tag), 64'(3));
    chk("single_value", 64'(cdb_value), 64'(42));
    // Pointer now at 3: unit 3 beats unit 1.
    post(1, $urandom, 1'b0);
    post(3, $urandom, 1'b0);
    step(1'b0, g);
    chk("rr_after_single", 64'(g), 64'(8'h08));
    step(1'b0, g);
    chk("rr_then_low", 64'(g), 64'(8'h02));
    do_reset(1'b1);

    // All units requesting from a fresh pointer.
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) post(i, $urandom, 1'($urandom_range(0, 1)));
      step(1'b0, g);
      chk("all_req_seq", 64'(g), 64'(8'h01 << (k % 8)));
    end
    @(posedge CLOCK_50);
    #1;
    chk("all_req_cnt", 64'(contention_cnt), 64'(9));
    chk("all_req_last_tag", 64'(cdb_tag), 64'(1));
    for (int t = 0; t < 16 && pend != '0; t++) step(1'b0, g);

    // Wrap-around from pointer 7.
    post(6, $urandom, 1'b0);
    step(1'b0, g);
    chk("wrap_setup", 64'(g), 64'(8'h40));
    post(7, $urandom, 1'b0);
    post(0, $urandom, 1'b0);
    step(1'b0, g);
    chk("wrap_first", 64'(g), 64'(8'h80));
    step(1'b0, g);
    chk("wrap_second", 64'(g), 64'(8'h01));

    // Flush during contention, then branch-fail passthrough from unit 5.
    post(4, $urandom, 1'b0);
    post(5, 32'd0, 1'b1);
    step(1'b1, g);
    chk("flush_grant", 64'(g), 64'(0));
    @(posedge CLOCK_50);
    #1;
    chk("flush_valid", 64'(cdb_valid), 64'(0));
    chk("flush_cnt_hold", 64'(contention_cnt), 64'(m_cnt));
    step(1'b0, g);
    chk("post_flush_grant", 64'(g), 64'(8'h10));
    step(1'b0, g);
    chk("bf_grant", 64'(g), 64'(8'h20));
    @(posedge CLOCK_50);
    #1;
    chk("bf_tag", 64'(cdb_tag), 64'(6));
    chk("bf_flag", 64'(cdb_branch_fail), 64'(1));
    chk("bf_value", 64'(cdb_value), 64'(0));

    // Random traffic with occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) post(i, $urandom, 1'($urandom_range(0, 1)));
      end
      step(($urandom_range(0, 9) == 0), g);
    end
    for (int t = 0; t < 16 && pend != '0; t++) step(1'b0, g);

    // Saturate the contention counter.
    for (int c = 0; c < 65536; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) post(i, $urandom, 1'($urandom_range(0, 1)));
      step(1'b0, g);
    end
    @(posedge CLOCK_50);
    #1;
    chk("cnt_saturated", 64'(contention_cnt), 64'(16'hFFFF));
    for (int c = 0; c < 3; c++) step(1'b0, g);
    @(posedge CLOCK_50);
    #1;
    chk("cnt_sat_hold", 64'(contention_cnt), 64'(16'hFFFF));

    for (int t = 0; t < 16 && pend != '0; t++) step(1'b0, g);
    step(1'b0, g);
    step(1'b0, g);
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
